// File: rtl/sq_commit_ctrl.sv
// Store-queue commit/drain control: allocates tags at tail, tracks address/commit state, drains head to memory.
// Status outputs come from registered state; a drain write holds o_mem_req/o_mem_tag until i_mem_ack.
module sq_commit_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_alloc,
  output logic [WIDTH-1:0] o_alloc_tag,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH:0]   o_count,
  input  logic             i_addr_val,
  input  logic [WIDTH-1:0] i_addr_tag,
  input  logic             i_commit,
  input  logic             i_flush,
  output logic             o_mem_req,
  output logic [WIDTH-1:0] o_mem_tag,
  input  logic             i_mem_ack
);

  localparam int SIZE = 2**WIDTH;

  typedef enum logic {IDLE, REQ} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [SIZE-1:0]  val_q, val_d, rdy_q, rdy_d, done_q, done_d;
  logic [WIDTH-1:0] mem_tag_q, mem_tag_d;

  logic [WIDTH-1:0] head_idx, cmt_idx, tail_idx;
  logic [WIDTH:0]   flush_cnt;
  logic [WIDTH-1:0] off;
  logic             full;

  assign head_idx  = head_q[WIDTH-1:0];
  assign cmt_idx   = cmt_q[WIDTH-1:0];
  assign tail_idx  = tail_q[WIDTH-1:0];
  assign full      = (head_idx == tail_idx) && (head_q[WIDTH] != tail_q[WIDTH]);
  assign flush_cnt = tail_q - cmt_q;

  assign o_full      = full;
  assign o_empty     = (head_q == tail_q);
  assign o_count     = tail_q - head_q;
  assign o_alloc_tag = tail_idx;
  assign o_mem_req   = (state_q == REQ);
  assign o_mem_tag   = mem_tag_q;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    cmt_d     = cmt_q;
    tail_d    = tail_q;
    val_d     = val_q;
    rdy_d     = rdy_q;
    done_d    = done_q;
    mem_tag_d = mem_tag_q;
    off       = '0;

    if (i_flush) begin
      // Uncommitted window is [cmt, tail); offset from cmt decides membership.
      for (int i = 0; i < SIZE; i++) begin
        off = WIDTH'(i) - cmt_idx;
        if ({1'b0, off} < flush_cnt) begin
          val_d[i] = 1'b0;
          rdy_d[i] = 1'b0;
        end
      end
      tail_d = cmt_q;
    end else begin
      if (i_alloc && !full) begin
        val_d[tail_idx]  = 1'b1;
        rdy_d[tail_idx]  = 1'b0;
        done_d[tail_idx] = 1'b0;
        tail_d           = tail_q + 1'b1;
      end
      if (i_addr_val && val_q[i_addr_tag]) begin
        rdy_d[i_addr_tag] = 1'b1;
      end
      if (i_commit && (cmt_q != tail_q)) begin
        done_d[cmt_idx] = 1'b1;
        cmt_d           = cmt_q + 1'b1;
      end
    end

    // Head entry is always committed, so it never overlaps the flush window or the alloc slot.
    case (state_q)
      IDLE: begin
        if (val_q[head_idx] && rdy_q[head_idx] && done_q[head_idx]) begin
          state_d   = REQ;
          mem_tag_d = head_idx;
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          val_d[head_idx]  = 1'b0;
          rdy_d[head_idx]  = 1'b0;
          done_d[head_idx] = 1'b0;
          head_d           = head_q + 1'b1;
          state_d          = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      head_q    <= '0;
      cmt_q     <= '0;
      tail_q    <= '0;
      val_q     <= '0;
      rdy_q     <= '0;
      done_q    <= '0;
      mem_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      cmt_q     <= cmt_d;
      tail_q    <= tail_d;
      val_q     <= val_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
      mem_tag_q <= mem_tag_d;
    end
  end

endmodule

// File: tb/tb_sq_commit_ctrl.sv
// Directed bench for sq_commit_ctrl at WIDTH=2: vector table plus reset and wrap sequences.
module tb_sq_commit_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_alloc;
  logic [1:0] o_alloc_tag;
  logic       o_full;
  logic       o_empty;
  logic [2:0] o_count;
  logic       i_addr_val;
  logic [1:0] i_addr_tag;
  logic       i_commit;
  logic       i_flush;
  logic       o_mem_req;
  logic [1:0] o_mem_tag;
  logic       i_mem_ack;

  int checks = 0;
  int errors = 0;
  logic full_seen;

  sq_commit_ctrl #(.WIDTH(2)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_alloc    (i_alloc),
    .o_alloc_tag(o_alloc_tag),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .i_addr_val (i_addr_val),
    .i_addr_tag (i_addr_tag),
    .i_commit   (i_commit),
    .i_flush    (i_flush),
    .o_mem_req  (o_mem_req),
    .o_mem_tag  (o_mem_tag),
    .i_mem_ack  (i_mem_ack)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       al;
    logic       av;
    logic [1:0] at;
    logic       cm;
    logic       fl;
    logic       ak;
    logic [9:0] exp;
  } vec_t;

  vec_t vq[$];

  // Expected packing: {alloc_tag, full, empty, count, mem_req, mem_tag}
  function automatic logic [9:0] outs();
    return {o_alloc_tag, o_full, o_empty, o_count, o_mem_req, o_mem_tag};
  endfunction

  task automatic add(input logic al, input logic av, input logic [1:0] at,
                     input logic cm, input logic fl, input logic ak,
                     input logic [1:0] et, input logic ef, input logic ee,
                     input logic [2:0] ec, input logic er, input logic [1:0] em);
    vec_t v;
    v.al = al; v.av = av; v.at = at; v.cm = cm; v.fl = fl; v.ak = ak;
    v.exp = {et, ef, ee, ec, er, em};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic al, input logic av, input logic [1:0] at,
                      input logic cm, input logic fl, input logic ak);
    i_alloc = al; i_addr_val = av; i_addr_tag = at;
    i_commit = cm; i_flush = fl; i_mem_ack = ak;
    @(posedge i_clk);
    #1;
    full_seen = full_seen | o_full;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_alloc = 1'b0; i_addr_val = 1'b0; i_addr_tag = 2'd0;
    i_commit = 1'b0; i_flush = 1'b0; i_mem_ack = 1'b0;
    full_seen = 1'b0;

    //    al av at cm fl ak   tag full emp cnt req mtag
    add(1, 0, 0, 0, 0, 0,   2'd1, 0, 0, 3'd1, 0, 2'd0);
    add(1, 0, 0, 0, 0, 0,   2'd2, 0, 0, 3'd2, 0, 2'd0);
    add(1, 0, 0, 0, 0, 0,   2'd3, 0, 0, 3'd3, 0, 2'd0);
    add(1, 0, 0, 0, 0, 0,   2'd0, 1, 0, 3'd4, 0, 2'd0);
    add(1, 0, 0, 0, 0, 0,   2'd0, 1, 0, 3'd4, 0, 2'd0);
    add(0, 1, 1, 1, 0, 0,   2'd0, 1, 0, 3'd4, 0, 2'd0);
    add(0, 0, 0, 1, 0, 0,   2'd0, 1, 0, 3'd4, 0, 2'd0);
    add(0, 0, 0, 0, 0, 0,   2'd0, 1, 0, 3'd4, 0, 2'd0);
    add(0, 1, 0, 0, 0, 0,   2'd0, 1, 0, 3'd4, 0, 2'd0);
    add(0, 0, 0, 0, 0, 0,   2'd0, 1, 0, 3'd4, 1, 2'd0);
    add(0, 0, 0, 0, 0, 0,   2'd0, 1, 0, 3'd4, 1, 2'd0);
    add(0, 0, 0, 0, 0, 1,   2'd0, 0, 0, 3'd3, 0, 2'd0);
    add(0, 0, 0, 0, 0, 0,   2'd0, 0, 0, 3'd3, 1, 2'd1);
    add(0, 0, 0, 0, 0, 1,   2'd0, 0, 0, 3'd2, 0, 2'd1);
    add(0, 0, 0, 1, 0, 0,   2'd0, 0, 0, 3'd2, 0, 2'd1);
    add(1, 0, 0, 0, 1, 0,   2'd3, 0, 0, 3'd1, 0, 2'd1);
    add(1, 0, 0, 0, 0, 0,   2'd0, 0, 0, 3'd2, 0, 2'd1);
    add(0, 1, 3, 1, 0, 0,   2'd0, 0, 0, 3'd2, 0, 2'd1);
    add(0, 1, 2, 0, 0, 0,   2'd0, 0, 0, 3'd2, 0, 2'd1);
    add(0, 0, 0, 0, 0, 0,   2'd0, 0, 0, 3'd2, 1, 2'd2);
    add(1, 0, 0, 0, 0, 1,   2'd1, 0, 0, 3'd2, 0, 2'd2);
    add(0, 1, 0, 1, 1, 0,   2'd0, 0, 0, 3'd1, 1, 2'd3);
    add(0, 0, 0, 0, 0, 1,   2'd0, 0, 1, 3'd0, 0, 2'd3);
    add(0, 1, 0, 1, 0, 1,   2'd0, 0, 1, 3'd0, 0, 2'd3);
    add(1, 0, 0, 0, 0, 0,   2'd1, 0, 0, 3'd1, 0, 2'd3);
    add(0, 0, 0, 1, 0, 0,   2'd1, 0, 0, 3'd1, 0, 2'd3);
    add(0, 0, 0, 0, 0, 0,   2'd1, 0, 0, 3'd1, 0, 2'd3);

    #12;
    chk("reset_outputs", {22'd0, outs()}, {22'd0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0});
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].al, vq[i].av, vq[i].at, vq[i].cm, vq[i].fl, vq[i].ak);
      chk($sformatf("vec%0d", i), {22'd0, outs()}, {22'd0, vq[i].exp});
    end

    // Head entry 0 is allocated and committed but not ready; make it ready and start a write.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_pre_req", {22'd0, outs()}, {22'd0, 2'd1, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0});
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {22'd0, outs()}, {22'd0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0});
    step(0, 0, 0, 0, 0, 1);
    chk("rst_held_outputs", {22'd0, outs()}, {22'd0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0});
    i_rst_n = 1'b1;

    full_seen = 1'b0;
    for (int it = 0; it < 6; it++) begin
      logic [1:0] t;
      t = 2'(it % 4);
      chk($sformatf("wrap%0d_alloc_tag", it), {30'd0, o_alloc_tag}, {30'd0, t});
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, t, 1, 0, 0);
      for (int k = 0; k < 6 && !o_mem_req; k++) step(0, 0, 0, 0, 0, 0);
      chk($sformatf("wrap%0d_req", it), {31'd0, o_mem_req}, 32'd1);
      chk($sformatf("wrap%0d_mem_tag", it), {30'd0, o_mem_tag}, {30'd0, t});
      step(0, 0, 0, 0, 0, 1);
      chk($sformatf("wrap%0d_req_drop", it), {31'd0, o_mem_req}, 32'd0);
    end
    chk("wrap_full_seen", {31'd0, full_seen}, 32'd0);
    chk("wrap_empty", {31'd0, o_empty}, 32'd1);
    chk("wrap_count", {29'd0, o_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sq_commit_ctrl.md
SQ_COMMIT_CTRL -- requirements
Module: sq_commit_ctrl

Interface
REQ-001 Parameter WIDTH, default 5, tag width; SIZE = 2**WIDTH queue entries.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_alloc  input  1  dispatch requests one new store entry this cycle.
REQ-005 o_alloc_tag  output  WIDTH  tag given to the allocating store (current tail index).
REQ-006 o_full / o_empty  output  1 each  queue full / queue empty, from registered state only.
REQ-007 o_count  output  WIDTH+1  number of occupied entries (0..SIZE).
REQ-008 i_addr_val  input  1  address generation done for entry i_addr_tag.
REQ-009 i_addr_tag  input  WIDTH  tag whose address became valid.
REQ-010 i_commit  input  1  oldest uncommitted store is architecturally retired.
REQ-011 i_flush  input  1  discard all uncommitted entries.
REQ-012 o_mem_req  output  1  request to write head store to data memory.
REQ-013 o_mem_tag  output  WIDTH  tag of store being written; stable while o_mem_req=1.
REQ-014 i_mem_ack  input  1  memory accepted the write for o_mem_tag.

Function
REQ-015 Pointers head, cmt, tail SHALL be WIDTH+1 bits; index = low WIDTH bits, wrap modulo SIZE; full when indices equal and MSBs differ, empty when all bits equal.
REQ-016 Per entry SHALL hold val, rdy (address valid), done (committed) bits.
REQ-017 Allocation SHALL occur when i_alloc=1 and o_full=0: entry[tail] val=1, rdy=0, done=0; tail+1; o_alloc_tag = tail index before the increment.
REQ-018 i_alloc while o_full=1 SHALL be ignored with no state change; full is not relieved by a same-cycle free.
REQ-019 i_addr_val SHALL set rdy of i_addr_tag only if that entry has val=1; otherwise ignored.
REQ-020 i_commit SHALL set done of entry[cmt] and advance cmt only if cmt != tail; otherwise ignored.
REQ-021 Drain FSM states: IDLE, REQ.
REQ-022 IDLE -> REQ when entry[head] has val, rdy and done all 1; o_mem_req=1, o_mem_tag=head index registered on the transition edge.
REQ-023 In REQ, o_mem_req and o_mem_tag SHALL hold until i_mem_ack=1; on ack, entry[head] cleared (val=rdy=done=0), head+1, FSM -> IDLE.
REQ-024 Minimum one IDLE cycle between consecutive writes; i_mem_ack in IDLE ignored.
REQ-025 i_flush SHALL clear val/rdy of every entry between cmt and tail and set tail = cmt in the same edge; committed entries and the drain FSM are unaffected.
REQ-026 i_flush has priority over i_alloc, i_addr_val and i_commit in the same cycle; i_mem_ack in that cycle is still honoured.
REQ-027 o_count = tail - head (WIDTH+1-bit modular subtraction), registered-state based.
REQ-028 Simultaneous alloc and ack-free SHALL both take effect; o_count unchanged.

Reset
REQ-029 On i_rst_n=0: head=cmt=tail=0, all val/rdy/done=0, FSM=IDLE, o_mem_req=0, o_mem_tag=0, o_empty=1, o_full=0, o_count=0, o_alloc_tag=0.
REQ-030 Reset asserted mid-transaction (in REQ) SHALL drop o_mem_req immediately (asynchronously) and abandon the write.

Verification (WIDTH=2, SIZE=4)
REQ-031 Fill: 5 cycles i_alloc=1 -> tags 0,1,2,3 granted, 5th ignored; o_full=1, o_count=4.
REQ-032 Ordered drain: alloc 2, addr_val tag1 then tag0, commit x2 -> o_mem_req with tag 0 first, ack, one IDLE cycle, then tag 1; o_empty=1 after second ack.
REQ-033 Blocking: tag0 committed but rdy=0, tag1 ready+committed -> no o_mem_req until i_addr_val tag0.
REQ-034 Flush: alloc 4, commit 1, i_flush -> tail=1, o_count=1, tags 1..3 invalid; next alloc gets tag 1.
REQ-035 Wrap: 6 alloc/commit/drain iterations -> tags cycle 0,1,2,3,0,1; o_full never set.
REQ-036 Async reset while o_mem_req=1 with ack withheld -> o_mem_req=0 same cycle, all outputs at REQ-029 values.
